// File: rtl/huffman_pkg.sv
// Shared types and constants for the Huffman sequencer and its code table.
package huffman_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAD,
        ST_DRAIN
    } state_t;

    localparam int WORD_W       = 32;
    localparam int MAX_CODE_LEN = 8;
    localparam int LEN_W        = 4;
    localparam int DRAIN_CYCLES = 2;
    localparam int BIT_CNT_W    = $clog2(WORD_W);

    function automatic logic [LEN_W-1:0] clamp_len(
        input logic [LEN_W-1:0] len,
        input logic [LEN_W-1:0] max_len
    );
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/huffman_code_table.sv
// Programmable symbol -> (code, length) table; lengths are clamped on write,
// read is combinational so a lookup sees the contents before a same-cycle write.
module huffman_code_table
    import huffman_pkg::*;
#(
    parameter int SYM_W  = 4,
    parameter int CODE_W = MAX_CODE_LEN
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [SYM_W-1:0]  wr_addr,
    input  logic [CODE_W-1:0] wr_code,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic [SYM_W-1:0]  rd_addr,
    output logic [CODE_W-1:0] rd_code,
    output logic [LEN_W-1:0]  rd_len
);

    localparam int               DEPTH   = 2 ** SYM_W;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(CODE_W);

    logic [CODE_W-1:0] code_mem [DEPTH];
    logic [LEN_W-1:0]  len_mem  [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                code_mem[i] <= '0;
                len_mem[i]  <= '0;
            end
        end else if (wr_en) begin
            code_mem[wr_addr] <= wr_code;
            len_mem[wr_addr]  <= clamp_len(wr_len, LEN_MAX);
        end
    end

    assign rd_code = code_mem[rd_addr];
    assign rd_len  = len_mem[rd_addr];

endmodule

// File: rtl/huffman_ctrl.sv
// Sequencer in front of the 32-bit Huffman bit packer: symbol lookup, zero
// padding to a word boundary, drain of the final word and packet accounting.
module huffman_ctrl
    import huffman_pkg::*;
#(
    parameter int SYM_W  = 4,
    parameter int CODE_W = MAX_CODE_LEN,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sym_valid,
    output logic              sym_ready,
    input  logic [SYM_W-1:0]  sym_data,
    input  logic              sym_last,
    input  logic              cfg_we,
    input  logic [SYM_W-1:0]  cfg_addr,
    input  logic [CODE_W-1:0] cfg_code,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic              cfg_err,
    output logic [CODE_W-1:0] coder_code,
    output logic [LEN_W-1:0]  coder_length,
    input  logic              coder_enable,
    output logic [CNT_W-1:0]  pkt_words,
    output logic              pkt_done,
    output logic              busy
);

    localparam int ROOM_W = BIT_CNT_W + 1;

    state_t                 state_reg;
    logic [BIT_CNT_W-1:0]   bit_cnt_reg;
    logic [1:0]             drain_cnt_reg;
    logic                   sym_ready_reg;
    logic                   cfg_err_reg;
    logic [CODE_W-1:0]      coder_code_reg;
    logic [LEN_W-1:0]       coder_length_reg;
    logic [CNT_W-1:0]       pkt_words_reg;
    logic                   pkt_done_reg;

    logic                   handshake;
    logic                   table_we;
    logic [CODE_W-1:0]      tbl_code;
    logic [LEN_W-1:0]       tbl_len;
    logic [BIT_CNT_W-1:0]   sym_base;
    logic [BIT_CNT_W-1:0]   sym_bit_cnt_next;
    logic [ROOM_W-1:0]      pad_room;
    logic [LEN_W-1:0]       pad_len;
    logic [BIT_CNT_W-1:0]   pad_bit_cnt_next;

    assign handshake = sym_valid & sym_ready_reg;
    assign table_we  = cfg_we & (state_reg == ST_IDLE);

    huffman_code_table #(
        .SYM_W  (SYM_W),
        .CODE_W (CODE_W)
    ) u_table (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (table_we),
        .wr_addr (cfg_addr),
        .wr_code (cfg_code),
        .wr_len  (cfg_len),
        .rd_addr (sym_data),
        .rd_code (tbl_code),
        .rd_len  (tbl_len)
    );

    // A packet always starts word-aligned, so the first symbol counts from zero.
    assign sym_base         = (state_reg == ST_IDLE) ? '0 : bit_cnt_reg;
    assign sym_bit_cnt_next = sym_base + BIT_CNT_W'(tbl_len);

    assign pad_room         = ROOM_W'(WORD_W) - {1'b0, bit_cnt_reg};
    assign pad_len          = (pad_room > ROOM_W'(CODE_W)) ? LEN_W'(CODE_W)
                                                           : pad_room[LEN_W-1:0];
    assign pad_bit_cnt_next = bit_cnt_reg + BIT_CNT_W'(pad_len);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            bit_cnt_reg      <= '0;
            drain_cnt_reg    <= '0;
            sym_ready_reg    <= 1'b0;
            cfg_err_reg      <= 1'b0;
            coder_code_reg   <= '0;
            coder_length_reg <= '0;
            pkt_words_reg    <= '0;
            pkt_done_reg     <= 1'b0;
        end else begin
            cfg_err_reg      <= cfg_we & (state_reg != ST_IDLE);
            pkt_done_reg     <= 1'b0;
            coder_code_reg   <= '0;
            coder_length_reg <= '0;

            if (coder_enable && (state_reg != ST_IDLE) && (pkt_words_reg != '1)) begin
                pkt_words_reg <= pkt_words_reg + CNT_W'(1);
            end

            case (state_reg)
                ST_IDLE, ST_RUN: begin
                    sym_ready_reg <= 1'b1;
                    if (handshake) begin
                        if (state_reg == ST_IDLE) begin
                            pkt_words_reg <= '0;
                        end
                        coder_code_reg   <= tbl_code;
                        coder_length_reg <= tbl_len;
                        bit_cnt_reg      <= sym_bit_cnt_next;
                        if (sym_last) begin
                            sym_ready_reg <= 1'b0;
                            drain_cnt_reg <= '0;
                            state_reg     <= (sym_bit_cnt_next == '0) ? ST_DRAIN : ST_PAD;
                        end else begin
                            state_reg <= ST_RUN;
                        end
                    end
                end

                ST_PAD: begin
                    sym_ready_reg    <= 1'b0;
                    coder_length_reg <= pad_len;
                    bit_cnt_reg      <= pad_bit_cnt_next;
                    if (pad_bit_cnt_next == '0) begin
                        drain_cnt_reg <= '0;
                        state_reg     <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    // Hold the coder idle long enough for its last word to surface.
                    if (drain_cnt_reg == 2'(DRAIN_CYCLES - 1)) begin
                        drain_cnt_reg <= '0;
                        pkt_done_reg  <= 1'b1;
                        sym_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end else begin
                        sym_ready_reg <= 1'b0;
                        drain_cnt_reg <= drain_cnt_reg + 2'd1;
                    end
                end

                default: begin
                    sym_ready_reg <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    assign sym_ready    = sym_ready_reg;
    assign cfg_err      = cfg_err_reg;
    assign coder_code   = coder_code_reg;
    assign coder_length = coder_length_reg;
    assign pkt_words    = pkt_words_reg;
    assign pkt_done     = pkt_done_reg;
    assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_huffman_ctrl.sv
// Bench for huffman_ctrl: a bit-queue reference model feeds a scoreboard, and a
// behavioural 32-bit packer model turns the DUT's code/length stream into words.
module tb_huffman_ctrl;

    localparam int SYM_W  = 4;
    localparam int CODE_W = 8;
    localparam int CNT_W  = 16;
    localparam int NSYM   = 2 ** SYM_W;

    logic              clock = 1'b0;
    logic              reset;
    logic              sym_valid;
    logic              sym_ready;
    logic [SYM_W-1:0]  sym_data;
    logic              sym_last;
    logic              cfg_we;
    logic [SYM_W-1:0]  cfg_addr;
    logic [CODE_W-1:0] cfg_code;
    logic [3:0]        cfg_len;
    logic              cfg_err;
    logic [CODE_W-1:0] coder_code;
    logic [3:0]        coder_length;
    logic              coder_enable;
    logic [CNT_W-1:0]  pkt_words;
    logic              pkt_done;
    logic              busy;

    huffman_ctrl #(
        .SYM_W  (SYM_W),
        .CODE_W (CODE_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .sym_data     (sym_data),
        .sym_last     (sym_last),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_code     (cfg_code),
        .cfg_len      (cfg_len),
        .cfg_err      (cfg_err),
        .coder_code   (coder_code),
        .coder_length (coder_length),
        .coder_enable (coder_enable),
        .pkt_words    (pkt_words),
        .pkt_done     (pkt_done),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_words[$];
    int          exp_pkt[$];
    int          ref_code[NSYM];
    int          ref_len[NSYM];
    bit          in_packet;
    logic [63:0] acc;
    int          acc_cnt;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Packer model and scoreboard monitor.
    initial begin : monitor
        logic [CODE_W-1:0] c;
        logic [3:0]        l;
        logic              done;
        logic [CNT_W-1:0]  pw;
        coder_enable = 1'b0;
        acc          = '0;
        acc_cnt      = 0;
        forever begin
            @(negedge clock);
            c    = coder_code;
            l    = coder_length;
            done = pkt_done;
            pw   = pkt_words;
            if (!reset && done) begin
                if (exp_pkt.size() == 0) check("unexpected_pkt_done", 1, 0);
                else check("pkt_words", 64'(pw), 64'(exp_pkt.pop_front()));
                check("words_outstanding", 64'(exp_words.size()), 0);
                check("coder_flushed", 64'(acc_cnt), 0);
            end
            @(posedge clock);
            #1;
            coder_enable = 1'b0;
            if (reset) begin
                acc     = '0;
                acc_cnt = 0;
            end else if (l != 0) begin
                acc     = acc | ((64'(c) & ((64'd1 << l) - 64'd1)) << acc_cnt);
                acc_cnt = acc_cnt + int'(l);
                check("coder_acc_le_39", 64'(acc_cnt <= 39), 1);
                if (acc_cnt >= 32) begin
                    coder_enable = 1'b1;
                    if (exp_words.size() == 0) check("unexpected_word", 1, 0);
                    else check("word", 64'(acc[31:0]), 64'(exp_words.pop_front()));
                    acc     = acc >> 32;
                    acc_cnt = acc_cnt - 32;
                end
            end
        end
    end

    task automatic cfg_write(input int a, input int code, input int len);
        cfg_we   = 1'b1;
        cfg_addr = SYM_W'(a);
        cfg_code = CODE_W'(code);
        cfg_len  = 4'(len);
        @(posedge clock);
        #1;
        cfg_we = 1'b0;
        check("cfg_err_idle", 64'(cfg_err), 0);
        ref_code[a] = code;
        ref_len[a]  = (len > CODE_W) ? CODE_W : len;
        $display("cfg write addr %0d code %02h len %0d", a, code, len);
    endtask

    task automatic send_packet(input int n, input int fixed_sym, input int gap_pct,
                               input int cfg_at, input int ca, input int cc, input int cl,
                               input bit wait_done);
        bit bq[$];
        int nwords = 0;
        int waits;
        for (int i = 0; i < n; i++) begin
            int s;
            bit err_exp;
            logic [31:0] w;
            err_exp = 1'b0;
            s = (fixed_sym >= 0) ? fixed_sym : int'($urandom_range(0, NSYM - 1));
            while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
                sym_valid = 1'b0;
                @(posedge clock);
                #1;
            end
            sym_valid = 1'b1;
            sym_data  = SYM_W'(s);
            sym_last  = (i == n - 1);
            cfg_we    = (i == cfg_at);
            cfg_addr  = SYM_W'(ca);
            cfg_code  = CODE_W'(cc);
            cfg_len   = 4'(cl);
            waits = 0;
            while (!sym_ready && waits < 50) begin
                @(posedge clock);
                #1;
                waits++;
            end
            if (!sym_ready) begin
                check("sym_ready_timeout", 0, 1);
                sym_valid = 1'b0;
                cfg_we    = 1'b0;
                return;
            end
            for (int b = 0; b < ref_len[s]; b++) bq.push_back(bit'((ref_code[s] >> b) & 1));
            while (bq.size() >= 32) begin
                for (int k = 0; k < 32; k++) w[k] = bq.pop_front();
                exp_words.push_back(w);
                nwords++;
            end
            if (i == cfg_at) begin
                if (!in_packet) begin
                    ref_code[ca] = cc;
                    ref_len[ca]  = (cl > CODE_W) ? CODE_W : cl;
                end else begin
                    err_exp = 1'b1;
                end
            end
            in_packet = 1'b1;
            @(posedge clock);
            #1;
            sym_valid = 1'b0;
            sym_last  = 1'b0;
            cfg_we    = 1'b0;
            if (i == cfg_at) check("cfg_err", 64'(cfg_err), 64'(err_exp));
        end
        if (bq.size() > 0) begin
            logic [31:0] w;
            while (bq.size() < 32) bq.push_back(1'b0);
            for (int k = 0; k < 32; k++) w[k] = bq.pop_front();
            exp_words.push_back(w);
            nwords++;
        end
        exp_pkt.push_back(nwords);
        check("sym_ready_after_last", 64'(sym_ready), 0);
        check("busy_after_last", 64'(busy), 1);
        $display("packet n %0d sym %0d gap %0d words %0d", n, fixed_sym, gap_pct, nwords);
        if (wait_done) begin
            waits = 0;
            while (busy && waits < 200) begin
                @(posedge clock);
                #1;
                waits++;
            end
            if (busy) check("drain_timeout", 64'(busy), 0);
            @(negedge clock);
            @(posedge clock);
            #1;
            in_packet = 1'b0;
        end
    endtask

    initial begin : stimulus
        reset     = 1'b1;
        sym_valid = 1'b0;
        sym_data  = '0;
        sym_last  = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_code  = '0;
        cfg_len   = '0;
        in_packet = 1'b0;
        for (int i = 0; i < NSYM; i++) begin
            ref_code[i] = 0;
            ref_len[i]  = 0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_sym_ready", 64'(sym_ready), 0);
        check("rst_outputs", 64'({cfg_err, coder_code, coder_length, pkt_words, pkt_done, busy}), 0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("idle_sym_ready", 64'(sym_ready), 1);
        check("idle_busy", 64'(busy), 0);

        // 33 bits of code 101 -> padding to 64 bits, two words
        cfg_write(1, 'h05, 3);
        send_packet(11, 1, 0, -1, 0, 0, 0, 1);

        // exactly one word of ones, no padding
        cfg_write(2, 'hFF, 8);
        send_packet(4, 2, 0, -1, 0, 0, 0, 1);

        // over-long length is clamped; write during RUN is rejected
        cfg_write(3, 'hA5, 12);
        send_packet(6, 3, 0, 2, 3, 'h0F, 4, 1);

        // same-cycle write and first symbol: first lookup sees the old entry
        send_packet(4, 3, 0, 0, 3, 'h03, 2, 1);

        // zero-length entries produce no bits and no words
        cfg_write(0, 0, 0);
        send_packet(6, 0, 0, -1, 0, 0, 0, 1);

        // random table and random gaps
        for (int a = 0; a < NSYM; a++) cfg_write(a, int'($urandom_range(0, 255)), int'($urandom_range(1, 8)));
        for (int p = 0; p < 4; p++) send_packet(25, -1, 50, -1, 0, 0, 0, 1);

        // reset in the middle of padding
        cfg_write(2, 'h15, 3);
        send_packet(5, 2, 0, -1, 0, 0, 0, 0);
        @(negedge clock);
        check("pad_active_len", 64'(coder_length != 0), 1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_sym_ready", 64'(sym_ready), 0);
        check("midrst_outputs", 64'({cfg_err, coder_code, coder_length, pkt_words, pkt_done, busy}), 0);
        exp_words.delete();
        exp_pkt.delete();
        for (int i = 0; i < NSYM; i++) begin
            ref_code[i] = 0;
            ref_len[i]  = 0;
        end
        in_packet = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post_rst_busy", 64'(busy), 0);
        @(posedge clock);
        #1;
        check("post_rst_sym_ready", 64'(sym_ready), 1);
        $display("reset during pad applied");
        // cleared table: these symbols must contribute no bits
        send_packet(3, 2, 0, -1, 0, 0, 0, 1);

        repeat (4) @(posedge clock);
        check("exp_words_empty", 64'(exp_words.size()), 0);
        check("exp_pkt_empty", 64'(exp_pkt.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
